// File: rtl/demux_2x2_buf.sv
// Registered 1-to-4 demultiplexer for 2-bit words with a one-entry holding
// register and valid/ready handshake per lane, plus an accepted-word counter.
module demux_2x2_buf #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       in,
  input  logic [1:0]       key,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       out1,
  output logic [1:0]       out2,
  output logic [1:0]       out3,
  output logic [1:0]       out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       last_key
);

  localparam int unsigned DATA_W = 2;
  localparam int unsigned LANES  = 4;

  logic [LANES-1:0]             valid_q, valid_d;
  logic [LANES-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [1:0]                   last_key_q, last_key_d;
  logic                         accept;

  // Selected lane can take a word if empty or being emptied this cycle.
  assign in_ready = ~valid_q[key] | out_ready[key];
  assign accept   = in_valid & in_ready;

  always_comb begin
    valid_d    = valid_q & ~out_ready;
    data_d     = data_q;
    count_d    = count_q;
    last_key_d = last_key_q;
    if (accept) begin
      valid_d[key] = 1'b1;
      data_d[key]  = in;
      count_d      = count_q + CNT_W'(1);
      last_key_d   = key;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      valid_q    <= '0;
      data_q     <= '0;
      count_q    <= '0;
      last_key_q <= '0;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      count_q    <= count_d;
      last_key_q <= last_key_d;
    end
  end

  assign out1      = data_q[0];
  assign out2      = data_q[1];
  assign out3      = data_q[2];
  assign out4      = data_q[3];
  assign out_valid = valid_q;
  assign count     = count_q;
  assign last_key  = last_key_q;

endmodule

// File: tb/tb_demux_2x2_buf.sv
// Randomized bench for demux_2x2_buf against a lane/queue-level model, plus
// directed scenarios with hand-computed expectations.
module tb_demux_2x2_buf;

  localparam int unsigned CNT_W = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [1:0]       in_d = '0;
  logic [1:0]       key = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       out1, out2, out3, out4;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = '0;
  logic [CNT_W-1:0] count;
  logic [1:0]       last_key;

  demux_2x2_buf #(.CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .in(in_d), .key(key), .in_valid(in_valid),
    .in_ready(in_ready), .out1(out1), .out2(out2), .out3(out3), .out4(out4),
    .out_valid(out_valid), .out_ready(out_ready), .count(count), .last_key(last_key)
  );

  always #5 clock = ~clock;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  chk_en   = 1'b0;

  // Reference state: which lanes hold a word, what they hold, counter, last key.
  bit [3:0] m_valid = '0;
  int       m_data[4] = '{0, 0, 0, 0};
  int       m_count = 0;
  int       m_last = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clock) begin : model
    bit rdy;
    if (!reset) begin
      m_valid = '0;
      for (int i = 0; i < 4; i++) m_data[i] = 0;
      m_count = 0;
      m_last  = 0;
    end else begin
      rdy = !m_valid[key] || out_ready[key];
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && out_ready[i]) m_valid[i] = 1'b0;
      if (in_valid && rdy) begin
        m_valid[key] = 1'b1;
        m_data[key]  = int'(in_d);
        m_count      = (m_count + 1) % (1 << CNT_W);
        m_last       = int'(key);
      end
    end
  end

  always @(negedge clock) begin : compare
    logic [1:0] dout[4];
    if (chk_en) begin
      dout[0] = out1; dout[1] = out2; dout[2] = out3; dout[3] = out4;
      check("out_valid", 32'(out_valid), 32'(m_valid));
      for (int i = 0; i < 4; i++)
        check($sformatf("out%0d", i + 1), 32'(dout[i]), 32'(m_data[i]));
      check("count", 32'(count), 32'(m_count));
      check("last_key", 32'(last_key), 32'(m_last));
      check("in_ready", 32'(in_ready), 32'(!m_valid[key] || out_ready[key]));
    end
  end

  // Drive one cycle of inputs, capture in_ready before the edge, return after it.
  task automatic cyc(input logic iv, input logic [1:0] d, input logic [1:0] k,
                     input logic [3:0] ordy, output logic rdy);
    in_valid  = iv;
    in_d      = d;
    key       = k;
    out_ready = ordy;
    #1;
    rdy = in_ready;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    logic r;
    reset = 1'b0;
    cyc(1'b0, 2'b00, 2'b00, 4'b0000, r);
    reset = 1'b1;
  endtask

  initial begin
    logic       rdy;
    logic       stalled;
    logic       iv;
    logic [1:0] hd, hk;

    @(posedge clock);
    #1;
    do_reset();
    chk_en = 1'b1;

    // Reset mid-operation: lanes 1 and 3 full, then reset with a word offered.
    cyc(1'b1, 2'b10, 2'b00, 4'b0000, rdy);
    cyc(1'b1, 2'b01, 2'b10, 4'b0000, rdy);
    check("fill_valid", 32'(out_valid), 32'h5);
    check("fill_out3", 32'(out3), 32'h1);
    reset = 1'b0;
    cyc(1'b1, 2'b11, 2'b01, 4'b0000, rdy);
    reset = 1'b1;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(count), 32'h0);
    check("rst_last_key", 32'(last_key), 32'h0);
    check("rst_outs", 32'({out1, out2, out3, out4}), 32'h0);

    // Basic routing with every consumer ready.
    cyc(1'b1, 2'b11, 2'b00, 4'b1111, rdy);
    check("route_out1", 32'({out_valid, out1}), 32'({4'b0001, 2'b11}));
    cyc(1'b1, 2'b10, 2'b01, 4'b1111, rdy);
    check("route_out2", 32'({out_valid, out2}), 32'({4'b0010, 2'b10}));
    cyc(1'b1, 2'b01, 2'b10, 4'b1111, rdy);
    check("route_out3", 32'({out_valid, out3}), 32'({4'b0100, 2'b01}));
    cyc(1'b1, 2'b00, 2'b11, 4'b1111, rdy);
    check("route_out4", 32'({out_valid, out4}), 32'({4'b1000, 2'b00}));
    check("route_count", 32'(count), 32'd4);
    check("route_last_key", 32'(last_key), 32'h3);

    // Backpressure on lane 2.
    do_reset();
    cyc(1'b1, 2'b01, 2'b01, 4'b0000, rdy);
    cyc(1'b1, 2'b10, 2'b01, 4'b0000, rdy);
    check("bp_stall_ready", 32'(rdy), 32'h0);
    check("bp_hold_out2", 32'(out2), 32'h1);
    cyc(1'b1, 2'b10, 2'b01, 4'b0010, rdy);
    check("bp_release_ready", 32'(rdy), 32'h1);
    check("bp_out2", 32'({out_valid[1], out2}), 32'({1'b1, 2'b10}));
    check("bp_count", 32'(count), 32'd2);

    // A stalled lane 1 does not block a word for lane 4.
    cyc(1'b0, 2'b00, 2'b00, 4'b0010, rdy);
    cyc(1'b1, 2'b01, 2'b00, 4'b0000, rdy);
    cyc(1'b1, 2'b11, 2'b11, 4'b0000, rdy);
    check("nb_ready", 32'(rdy), 32'h1);
    check("nb_lanes", 32'({out_valid, out1, out4}), 32'({4'b1001, 2'b01, 2'b11}));

    // Drain and accept on lane 3 in the same cycle.
    cyc(1'b1, 2'b00, 2'b10, 4'b0000, rdy);
    cyc(1'b1, 2'b11, 2'b10, 4'b0100, rdy);
    check("da_ready", 32'(rdy), 32'h1);
    check("da_out3", 32'({out_valid[2], out3}), 32'({1'b1, 2'b11}));

    // Counter wrap.
    do_reset();
    for (int n = 0; n < 256; n++)
      cyc(1'b1, 2'($urandom), 2'($urandom), 4'b1111, rdy);
    check("wrap_256", 32'(count), 32'd0);
    cyc(1'b1, 2'($urandom), 2'($urandom), 4'b1111, rdy);
    check("wrap_257", 32'(count), 32'd1);

    // Random traffic with occasional reset; stalled words are held stable.
    stalled = 1'b0;
    hd = '0;
    hk = '0;
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      if (stalled) begin
        iv = 1'b1;
      end else begin
        iv = ($urandom_range(0, 3) != 0);
        hd = 2'($urandom);
        hk = 2'($urandom);
      end
      cyc(iv, hd, hk, 4'($urandom), rdy);
      stalled = iv && !rdy;
    end
    reset = 1'b1;
    cyc(1'b0, 2'b00, 2'b00, 4'b0000, rdy);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_2x2_buf.md
Name: demux_2x2_buf

Overview:
- Registered 1-to-4 demultiplexer for 2-bit data; the routing counterpart of the 4:1 2-bit selector used elsewhere in the datapath.
- A 2-bit word presented with a 2-bit key is steered into one of four output lanes. Each lane has a one-entry holding register and a valid/ready handshake.
- Sits between a single producer and four independent consumers. Backpressure on one lane does not stall words bound for other lanes, except through the input handshake of the word currently offered.

Parameters:
- CNT_W, 8, width of the accepted-word counter (wraps modulo 2^CNT_W).

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset (sampled on rising edge of clock)
- in  input  2  data word to route
- key  input  2  destination lane: 00 -> lane 1, 01 -> lane 2, 10 -> lane 3, 11 -> lane 4
- in_valid  input  1  producer offers in/key this cycle
- in_ready  output  1  block can accept the offered word this cycle
- out1, out2, out3, out4  output  2 each  lane holding-register contents
- out_valid  output  4  bit i-1 set when lane i holds a word
- out_ready  input  4  bit i-1 set when consumer i takes lane i's word this cycle
- count  output  CNT_W  number of accepted words, modulo 2^CNT_W
- last_key  output  2  key of the most recently accepted word

Behaviour:
- Reset (reset==0 at a rising edge):
  - out_valid=0000; out1..out4=00; count=0; last_key=00.
  - Reset overrides any transfer in the same cycle; words held in lanes are discarded.
- Lane state: each lane is EMPTY (out_valid bit 0) or FULL (out_valid bit 1).
- Drain: lane i drains when FULL and out_ready[i-1]=1.
- Accept:
  - Accept occurs when in_valid=1 and in_ready=1.
  - in_ready is combinational: 1 when the lane selected by key is EMPTY, or FULL and draining this cycle.
  - in_ready depends only on key, out_valid and out_ready; it must not depend on in_valid.
- Lane transitions per clock:
  - EMPTY + accept -> FULL; out<i> <= in.
  - FULL + drain, no accept -> EMPTY; data register holds its last value.
  - FULL + drain + accept (same lane) -> FULL; out<i> <= new in. Full throughput, one word per cycle on one lane.
  - FULL, no drain -> FULL; data unchanged.
  - EMPTY with out_ready=1 -> no effect.
- Latency: a word accepted at edge N is visible on out<i> with out_valid set after edge N; minimum 1 cycle in-to-out.
- Independence:
  - Drains on non-selected lanes proceed in the same cycle as an accept on another lane.
  - Up to 4 drains and 1 accept can occur per cycle.
- Data stability: while a lane is FULL and not draining, out<i> is stable.
- Counter and key capture on each accept:
  - count <= count+1, wrapping from 2^CNT_W-1 to 0.
  - last_key <= key.
  - Neither changes without an accept.
- Input stability: the producer holds in/key stable while in_valid=1 and in_ready=0. The block requires nothing else of the producer.
- No combinational path from in or in_valid to any output.

Test Plan:
- Reset mid-operation:
  - Stimulus: fill lanes 1 and 3 (in=10, key=00; in=01, key=10); drive reset=0 for one edge with in_valid=1.
  - Required: out_valid=0000, count=0, last_key=00, out1..4=00; the word offered during reset is not accepted.
- Basic routing:
  - Stimulus: out_ready=1111; send in=11/key=00, in=10/key=01, in=01/key=10, in=00/key=11 on consecutive cycles.
  - Required: each word appears on out1..out4 respectively one cycle later with the matching valid bit; count=4; last_key=11.
- Backpressure:
  - Stimulus: out_ready=0000; send in=01/key=01, then in=10/key=01.
  - Required: second cycle in_ready=0 and out2 stays 01.
  - Then raise out_ready[1]=1. Required: in_ready=1 that cycle; after the edge out2=10, out_valid[1]=1, count=2.
- Non-blocking lanes:
  - Stimulus: lane 1 FULL with out_ready[0]=0; send in=11/key=11.
  - Required: accepted immediately; out4=11; lane 1 unchanged.
- Simultaneous drain and accept:
  - Stimulus: lane 3 FULL with 00; out_ready[2]=1; in=11/key=10 accepted the same cycle.
  - Required: out3=11, out_valid[2] stays 1.
- Counter wrap:
  - Stimulus: CNT_W=8, out_ready=1111, 256 accepts.
  - Required: count=0 after the 256th accept and 1 after the 257th.
